// File: rtl/uart_tx_engine_if.sv
// Transmit-side bundle between the UART controller (master) and the serialiser (slave).
// Carries the frame request and byte in one direction, status and the serial line back.
interface uart_tx_engine_if;
  logic       tx_enable;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_serial;
  logic       tx_done;

  modport master (
    output tx_enable, tx_start, tx_data,
    input  tx_busy, tx_serial, tx_done
  );

  modport slave (
    input  tx_enable, tx_start, tx_data,
    output tx_busy, tx_serial, tx_done
  );
endinterface

// File: rtl/uart_tx_engine.sv
// 8-bit UART serialiser: start, 8 data LSB-first, optional parity, 1-2 stop bits; outputs registered.
// Latency: line drops one cycle after acceptance; requests arriving while busy are dropped, not queued.
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_engine_if.slave tx
);

  localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic            ODD       = 1'(PARITY_ODD);

  if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
    $fatal(1, "uart_tx_engine: CLKS_PER_BIT must be >= 2 and STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cyc_cnt, cyc_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic          stop_cnt, stop_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          serial_q, serial_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          accept;
  logic          bit_end;

  assign accept  = (state == IDLE) && tx.tx_start && tx.tx_enable;
  assign bit_end = (cyc_cnt == CYC_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_nxt = state;
    cyc_nxt   = '0;
    bit_nxt   = bit_cnt;
    stop_nxt  = stop_cnt;
    shreg_nxt = shreg;
    if (state != IDLE && !bit_end) begin
      cyc_nxt = cyc_cnt + CW'(1);
    end
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = START;
          shreg_nxt = tx.tx_data;
        end
      end
      START: begin
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        if (bit_end) begin
          // 3-bit counter wraps 7 -> 0 on the way out of DATA
          bit_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_nxt = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (stop_cnt == STOP_LAST) begin
            state_nxt = IDLE;
            stop_nxt  = 1'b0;
          end else begin
            stop_nxt  = stop_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: computed from the upcoming state so the outputs can be registered
  always_comb begin
    serial_d = 1'b1;
    busy_d   = (state_nxt != IDLE);
    done_d   = (state == STOP) && (state_nxt == IDLE);
    case (state_nxt)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shreg_nxt[bit_nxt];
      PARITY:  serial_d = (^shreg_nxt) ^ ODD;
      default: serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cyc_cnt  <= cyc_nxt;
      bit_cnt  <= bit_nxt;
      stop_cnt <= stop_nxt;
      shreg    <= shreg_nxt;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx.tx_serial = serial_q;
  assign tx.tx_busy   = busy_q;
  assign tx.tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: four parameter sets driven in parallel, a frame-level reference model
// checked every cycle, plus literal expectations on captured frames.
module tb_uart_tx_engine;

  localparam int CPB  = 4;
  localparam int NCFG = 4;
  localparam int LOGN = 128;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_enable = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_engine_if ifa ();
  uart_tx_engine_if ifb ();
  uart_tx_engine_if ifc ();
  uart_tx_engine_if ifd ();

  assign ifa.tx_enable = tx_enable; assign ifa.tx_start = tx_start; assign ifa.tx_data = tx_data;
  assign ifb.tx_enable = tx_enable; assign ifb.tx_start = tx_start; assign ifb.tx_data = tx_data;
  assign ifc.tx_enable = tx_enable; assign ifc.tx_start = tx_start; assign ifc.tx_data = tx_data;
  assign ifd.tx_enable = tx_enable; assign ifd.tx_start = tx_start; assign ifd.tx_data = tx_data;

  // cfg0: no parity 1 stop; cfg1: even parity; cfg2: odd parity; cfg3: even parity 2 stop
  uart_tx_engine #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_a (.clk(clk), .rst_n(rst_n), .tx(ifa));
  uart_tx_engine #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_b (.clk(clk), .rst_n(rst_n), .tx(ifb));
  uart_tx_engine #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u_c (.clk(clk), .rst_n(rst_n), .tx(ifc));
  uart_tx_engine #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2))
    u_d (.clk(clk), .rst_n(rst_n), .tx(ifd));

  logic [NCFG-1:0] act_ser, act_busy, act_done;
  assign act_ser  = {ifd.tx_serial, ifc.tx_serial, ifb.tx_serial, ifa.tx_serial};
  assign act_busy = {ifd.tx_busy,   ifc.tx_busy,   ifb.tx_busy,   ifa.tx_busy};
  assign act_done = {ifd.tx_done,   ifc.tx_done,   ifb.tx_done,   ifa.tx_done};

  function automatic int pe(input int i); return (i == 0) ? 0 : 1; endfunction
  function automatic int po(input int i); return (i == 2) ? 1 : 0; endfunction
  function automatic int sb(input int i); return (i == 3) ? 2 : 1; endfunction
  function automatic int fr_len(input int i); return CPB * (9 + pe(i) + sb(i)); endfunction

  // Bit idx of the frame: 0 start, 1..8 data LSB first, 9 parity if present, then stop bits
  function automatic logic frame_bit(input int i, input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (pe(i) == 1 && idx == 9) return (^b) ^ (po(i) == 1);
    return 1'b1;
  endfunction

  // Reference model: cycles elapsed since acceptance per configuration
  logic [NCFG-1:0] m_busy, m_done;
  int              m_t [NCFG];
  logic [7:0]      m_byte [NCFG];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= '0;
      m_done <= '0;
      for (int i = 0; i < NCFG; i++) begin
        m_t[i]    <= 0;
        m_byte[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < NCFG; i++) begin
        if (m_busy[i]) begin
          m_t[i]    <= m_t[i] + 1;
          m_done[i] <= (m_t[i] + 1 == fr_len(i));
          m_busy[i] <= (m_t[i] + 1 != fr_len(i));
        end else begin
          m_done[i] <= 1'b0;
          if (tx_start && tx_enable) begin
            m_busy[i] <= 1'b1;
            m_t[i]    <= 0;
            m_byte[i] <= tx_data;
          end
        end
      end
    end
  end

  function automatic logic exp_ser(input int i);
    return m_busy[i] ? frame_bit(i, m_byte[i], m_t[i] / CPB) : 1'b1;
  endfunction

  task automatic chk(input string name, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cfg%0d actual=%0d required=%0d at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NCFG; i++) begin
      chk("model_serial", i, int'(act_ser[i]),  int'(exp_ser(i)));
      chk("model_busy",   i, int'(act_busy[i]), int'(m_busy[i]));
      chk("model_done",   i, int'(act_done[i]), int'(m_done[i]));
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
  endtask

  // Per-frame logs; index t = sample after acceptance edge + t
  logic lser  [NCFG][LOGN];
  logic lbusy [NCFG][LOGN];
  logic ldone [NCFG][LOGN];
  int   logn;

  task automatic run_frame(input logic [7:0] d, input logic en, input int n,
                           input int stop_start_t, input int new_d_t, input logic [7:0] new_d,
                           input int pulse_t, input int drop_en_t);
    step();
    tx_data   = d;
    tx_enable = en;
    tx_start  = 1'b1;
    logn      = n;
    for (int t = 0; t < n; t++) begin
      step();
      for (int i = 0; i < NCFG; i++) begin
        lser[i][t]  = act_ser[i];
        lbusy[i][t] = act_busy[i];
        ldone[i][t] = act_done[i];
      end
      if (t == stop_start_t) tx_start = 1'b0;
      if (t == new_d_t) tx_data = new_d;
      if (pulse_t >= 0 && t == pulse_t) tx_start = 1'b1;
      if (pulse_t >= 0 && t == pulse_t + 1) tx_start = 1'b0;
      if (t == drop_en_t) tx_enable = 1'b0;
    end
    tx_start  = 1'b0;
    tx_enable = 1'b1;
  endtask

  function automatic logic [7:0] cap_byte(input int i, input int t0);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = lser[i][t0 + CPB*(b+1) + 1];
    return r;
  endfunction

  function automatic int busy_cnt(input int i);
    int c = 0;
    for (int t = 0; t < logn; t++) if (lbusy[i][t]) c++;
    return c;
  endfunction

  function automatic int done_cnt(input int i);
    int c = 0;
    for (int t = 0; t < logn; t++) if (ldone[i][t]) c++;
    return c;
  endfunction

  function automatic int first_done(input int i);
    for (int t = 0; t < logn; t++) if (ldone[i][t]) return t;
    return -1;
  endfunction

  function automatic int last_done(input int i);
    int r = -1;
    for (int t = 0; t < logn; t++) if (ldone[i][t]) r = t;
    return r;
  endfunction

  function automatic int high_cnt(input int i, input int a, input int b);
    int c = 0;
    for (int t = a; t <= b; t++) if (lser[i][t]) c++;
    return c;
  endfunction

  initial begin
    logn = 0;
    repeat (3) step();
    for (int i = 0; i < NCFG; i++) begin
      chk("reset_serial", i, int'(act_ser[i]), 1);
      chk("reset_busy",   i, int'(act_busy[i]), 0);
      chk("reset_done",   i, int'(act_done[i]), 0);
    end
    rst_n = 1'b1;
    repeat (2) step();

    // Basic 0xA5 frame
    run_frame(8'hA5, 1'b1, 60, 0, -1, 8'h00, -1, -1);
    chk("a5_start_bit", 0, int'(lser[0][1]), 0);
    chk("a5_data",      0, int'(cap_byte(0, 0)), 8'hA5);
    chk("a5_stop_bit",  0, int'(lser[0][37]), 1);
    chk("a5_busy_len",  0, busy_cnt(0), 40);
    chk("a5_done_at",   0, first_done(0), 40);
    chk("a5_done_cnt",  0, done_cnt(0), 1);

    // Parity variants with 0x07
    run_frame(8'h07, 1'b1, 60, 0, -1, 8'h00, -1, -1);
    chk("p07_data",       1, int'(cap_byte(1, 0)), 8'h07);
    chk("p07_even_par",   1, int'(lser[1][37]), 1);
    chk("p07_even_len",   1, first_done(1), 44);
    chk("p07_odd_par",    2, int'(lser[2][37]), 0);
    chk("p07_odd_len",    2, first_done(2), 44);
    chk("p07_2stop_high", 3, high_cnt(3, 40, 47), 8);
    chk("p07_2stop_len",  3, first_done(3), 48);

    // tx_start with tx_enable low is ignored
    run_frame(8'h5A, 1'b0, 50, 0, -1, 8'h00, -1, -1);
    chk("dis_busy",   0, busy_cnt(0), 0);
    chk("dis_done",   0, done_cnt(0), 0);
    chk("dis_serial", 0, high_cnt(0, 0, 49), 50);

    // tx_enable dropped mid-frame: frame still completes
    run_frame(8'hC3, 1'b1, 60, 0, -1, 8'h00, -1, 12);
    chk("endrop_data", 0, int'(cap_byte(0, 0)), 8'hC3);
    chk("endrop_busy", 0, busy_cnt(0), 40);
    chk("endrop_done", 0, first_done(0), 40);

    // Start pulse and data change while busy
    run_frame(8'hA5, 1'b1, 100, 0, 10, 8'h3C, 10, -1);
    chk("busy_start_data", 0, int'(cap_byte(0, 0)), 8'hA5);
    chk("busy_start_done", 0, done_cnt(0), 1);
    chk("busy_start_len",  0, busy_cnt(0), 40);

    // Asynchronous reset during data bit 3
    step();
    tx_data  = 8'hF0;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    repeat (17) step();
    chk("pre_rst_busy", 0, int'(act_busy[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_serial", 0, int'(act_ser[0]), 1);
    chk("async_rst_busy",   0, int'(act_busy[0]), 0);
    compare_all();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    run_frame(8'h81, 1'b1, 60, 0, -1, 8'h00, -1, -1);
    chk("post_rst_data", 0, int'(cap_byte(0, 0)), 8'h81);
    chk("post_rst_busy", 0, busy_cnt(0), 40);
    chk("post_rst_done", 0, first_done(0), 40);

    // Back-to-back frames with tx_start held high
    run_frame(8'h55, 1'b1, 100, 41, 0, 8'hAA, -1, -1);
    chk("b2b_first_data",  0, int'(cap_byte(0, 0)), 8'h55);
    chk("b2b_gap_high",    0, int'(lser[0][40]), 1);
    chk("b2b_gap_idle",    0, int'(lbusy[0][40]), 0);
    chk("b2b_second_start",0, int'(lser[0][41]), 0);
    chk("b2b_second_data", 0, int'(cap_byte(0, 41)), 8'hAA);
    chk("b2b_done_cnt",    0, done_cnt(0), 2);
    chk("b2b_done_space",  0, last_done(0) - first_done(0), 41);

    repeat (4) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
